// File: rtl/jtdsp16_sio_rx.sv
// Deserialises DSP16 SIO output (ock/do/sadd/old) into 16-bit words + 8-bit addresses, routed to left/right.
// Latency: word/left/right and strobes register on the clk edge that samples the 16th bit.
// No backpressure: the serial stream is free-running. Define JTDSP16_SIO_RX_ERR_EN for frame_err_o/err_cnt_o.
module jtdsp16_sio_rx #(
  parameter logic [7:0] LEFT_ADDR  = 8'h00,
  parameter logic [7:0] RIGHT_ADDR = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen_i,
  input  logic        ock_i,
  input  logic        sio_do_i,
  input  logic        sadd_i,
  input  logic        old_i,
  output logic [15:0] word_o,
  output logic [7:0]  addr_o,
  output logic        word_stb_o,
  output logic [15:0] left_o,
  output logic [15:0] right_o,
  output logic        pair_stb_o,
  output logic        frame_err_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      state_q;
  logic        ock_l_q;
  logic [15:0] sh_q;
  logic [7:0]  ash_q;
  logic [4:0]  bcnt_q;
  logic [15:0] word_q;
  logic [7:0]  addr_q;
  logic [15:0] left_q;
  logic [15:0] right_q;
  logic        word_stb_q;
  logic        pair_stb_q;
`ifdef JTDSP16_SIO_RX_ERR_EN
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;
`endif

  logic        ev;
  logic [15:0] sh_d;
  logic [7:0]  ash_d;

  assign ev    = cen_i & ock_i & ~ock_l_q;
  assign sh_d  = {sh_q[14:0], sio_do_i};
  assign ash_d = {ash_q[6:0], sadd_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ock_l_q    <= 1'b0;
      sh_q       <= 16'd0;
      ash_q      <= 8'd0;
      bcnt_q     <= 5'd0;
      word_q     <= 16'd0;
      addr_q     <= 8'd0;
      left_q     <= 16'd0;
      right_q    <= 16'd0;
      word_stb_q <= 1'b0;
      pair_stb_q <= 1'b0;
`ifdef JTDSP16_SIO_RX_ERR_EN
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      // strobes drop every clk regardless of cen
      word_stb_q <= 1'b0;
      pair_stb_q <= 1'b0;
`ifdef JTDSP16_SIO_RX_ERR_EN
      frame_err_q <= 1'b0;
`endif
      if (cen_i) begin
        ock_l_q <= ock_i;
        case (state_q)
          IDLE: begin
            if (ev && !old_i) begin
              sh_q    <= {15'd0, sio_do_i};
              ash_q   <= {7'd0, sadd_i};
              bcnt_q  <= 5'd1;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (ev && bcnt_q == 5'd15) begin
              word_q     <= sh_d;
              addr_q     <= ash_q;
              word_stb_q <= 1'b1;
              // RIGHT_ADDR wins when both parameters match
              if (ash_q == RIGHT_ADDR) begin
                right_q    <= sh_d;
                pair_stb_q <= 1'b1;
              end else if (ash_q == LEFT_ADDR) begin
                left_q <= sh_d;
              end
              bcnt_q  <= bcnt_q + 5'd1;
              state_q <= old_i ? IDLE : HOLD;
            end else if (old_i) begin
              sh_q    <= 16'd0;
              ash_q   <= 8'd0;
              bcnt_q  <= 5'd0;
              state_q <= IDLE;
`ifdef JTDSP16_SIO_RX_ERR_EN
              frame_err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
            end else if (ev) begin
              sh_q   <= sh_d;
              bcnt_q <= bcnt_q + 5'd1;
              if (bcnt_q < 5'd8) ash_q <= ash_d;
            end
          end
          HOLD: begin
            if (old_i) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign word_o     = word_q;
  assign addr_o     = addr_q;
  assign word_stb_o = word_stb_q;
  assign left_o     = left_q;
  assign right_o    = right_q;
  assign pair_stb_o = pair_stb_q;
`ifdef JTDSP16_SIO_RX_ERR_EN
  assign frame_err_o = frame_err_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign frame_err_o = 1'b0;
  assign err_cnt_o   = 8'h00;
`endif

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Bench for jtdsp16_sio_rx: frame-level reference model compared against the DUT every clk.
module tb_jtdsp16_sio_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cen_i = 1'b0;
  logic        ock_i = 1'b0;
  logic        sio_do_i = 1'b0;
  logic        sadd_i = 1'b0;
  logic        old_i = 1'b1;
  logic [15:0] word_o, left_o, right_o;
  logic [7:0]  addr_o, err_cnt_o;
  logic        word_stb_o, pair_stb_o, frame_err_o;

  jtdsp16_sio_rx dut (
    .clk(clk), .rst_n(rst_n), .cen_i(cen_i), .ock_i(ock_i),
    .sio_do_i(sio_do_i), .sadd_i(sadd_i), .old_i(old_i),
    .word_o(word_o), .addr_o(addr_o), .word_stb_o(word_stb_o),
    .left_o(left_o), .right_o(right_o), .pair_stb_o(pair_stb_o),
    .frame_err_o(frame_err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int wstb_cnt = 0, pstb_cnt = 0, ferr_cnt = 0;

  // reference model state: what the outputs must be after the last clk edge
  logic [15:0] e_word, e_left, e_right;
  logic [7:0]  e_addr, e_err;
  logic        e_wstb, e_pstb, e_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("word", word_o, e_word);
      check("addr", addr_o, e_addr);
      check("word_stb", word_stb_o, e_wstb);
      check("left", left_o, e_left);
      check("right", right_o, e_right);
      check("pair_stb", pair_stb_o, e_pstb);
      check("frame_err", frame_err_o, e_ferr);
      check("err_cnt", err_cnt_o, e_err);
      if (word_stb_o === 1'b1) wstb_cnt++;
      if (pair_stb_o === 1'b1) pstb_cnt++;
      if (frame_err_o === 1'b1) ferr_cnt++;
    end
  end

  task automatic model_reset();
    e_word = '0; e_left = '0; e_right = '0; e_addr = '0; e_err = '0;
    e_wstb = 0; e_pstb = 0; e_ferr = 0;
  endtask

  task automatic model_word(input logic [15:0] data, input logic [7:0] addr);
    e_word = data;
    e_addr = addr;
    e_wstb = 1'b1;
    if (addr == 8'h01) begin
      e_right = data;
      e_pstb  = 1'b1;
    end else if (addr == 8'h00) begin
      e_left = data;
    end
  endtask

  task automatic model_err();
`ifdef JTDSP16_SIO_RX_ERR_EN
    e_ferr = 1'b1;
    if (e_err != 8'hFF) e_err = e_err + 8'd1;
`endif
  endtask

  // one clk: drive, let the edge happen, strobes from the previous edge expire
  task automatic tick(input logic c, input logic o, input logic d, input logic s, input logic ld);
    cen_i = c; ock_i = o; sio_do_i = d; sadd_i = s; old_i = ld;
    @(posedge clk);
    #1;
    e_wstb = 1'b0; e_pstb = 1'b0; e_ferr = 1'b0;
  endtask

  // cen=0 cycles carry arbitrary garbage that must be ignored
  task automatic noise();
    repeat ($urandom_range(0, 2))
      tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic ccyc(input logic o, input logic d, input logic s, input logic ld);
    noise();
    tick(1'b1, o, d, s, ld);
  endtask

  task automatic send_frame(input logic [15:0] data, input logic [7:0] addr, input int nbits, input bit coinc);
    logic d, s;
    for (int i = 0; i < nbits; i++) begin
      d = (i < 16) ? data[15-i] : 1'($urandom);
      s = (i < 8) ? addr[7-i] : 1'($urandom);
      ccyc(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      ccyc(1'b1, d, s, coinc && i == 15);
      if (i == 15) model_word(data, addr);
    end
    if (!(coinc && nbits == 16)) begin
      ccyc(1'b0, 1'($urandom), 1'($urandom), 1'b1);
      if (nbits < 16) model_err();
    end
  endtask

  // idle gap: rising ock with old high must not start a frame
  task automatic gap();
    repeat ($urandom_range(0, 3)) begin
      ccyc(1'b0, 1'($urandom), 1'($urandom), 1'b1);
      ccyc(1'b1, 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  int w0, p0, f0, nb, r;
  logic [15:0] rd;
  logic [7:0]  ra;
  bit          co;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst word", word_o, 16'h0000);
    check("rst left", left_o, 16'h0000);
    check("rst right", right_o, 16'h0000);
    check("rst err_cnt", err_cnt_o, 8'h00);

    // left word
    w0 = wstb_cnt; p0 = pstb_cnt;
    send_frame(16'hA55A, 8'h00, 16, 1'b0);
    gap();
    check("left A55A", left_o, 16'hA55A);
    check("left addr", addr_o, 8'h00);
    check("left word_stb count", wstb_cnt - w0, 1);
    check("left pair_stb count", pstb_cnt - p0, 0);

    // stereo pair
    w0 = wstb_cnt; p0 = pstb_cnt;
    send_frame(16'h1234, 8'h00, 16, 1'b0);
    gap();
    send_frame(16'hFEDC, 8'h01, 16, 1'b0);
    gap();
    check("pair left", left_o, 16'h1234);
    check("pair right", right_o, 16'hFEDC);
    check("pair word_stb count", wstb_cnt - w0, 2);
    check("pair pair_stb count", pstb_cnt - p0, 1);

    // other address
    p0 = pstb_cnt;
    send_frame(16'h7FFF, 8'h80, 16, 1'b0);
    gap();
    check("other word", word_o, 16'h7FFF);
    check("other addr", addr_o, 8'h80);
    check("other left kept", left_o, 16'h1234);
    check("other right kept", right_o, 16'hFEDC);
    check("other pair_stb count", pstb_cnt - p0, 0);

    // cen gating: toggling with cen low does nothing
    w0 = wstb_cnt;
    repeat (60) tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("cen gated word", word_o, 16'h7FFF);
    check("cen gated word_stb count", wstb_cnt - w0, 0);

    // overrun: 20 bits, first 16 kept
    w0 = wstb_cnt;
    send_frame(16'h0F0F, 8'h00, 20, 1'b0);
    gap();
    check("overrun word", word_o, 16'h0F0F);
    check("overrun word_stb count", wstb_cnt - w0, 1);

    // old rising with the 16th bit, next frame follows without an old pulse
    send_frame(16'hBEEF, 8'h01, 16, 1'b1);
    send_frame(16'h0102, 8'h00, 16, 1'b0);
    gap();
    check("coinc right", right_o, 16'hBEEF);
    check("coinc next left", left_o, 16'h0102);

    // framing error after 9 bits
    w0 = wstb_cnt; f0 = ferr_cnt;
    send_frame(16'hDEAD, 8'h00, 9, 1'b0);
    gap();
    check("ferr word_stb count", wstb_cnt - w0, 0);
`ifdef JTDSP16_SIO_RX_ERR_EN
    check("ferr err_cnt", err_cnt_o, 8'd1);
    check("ferr pulse count", ferr_cnt - f0, 1);
`else
    check("ferr err_cnt", err_cnt_o, 8'd0);
    check("ferr pulse count", ferr_cnt - f0, 0);
`endif
    send_frame(16'h5AA5, 8'h00, 16, 1'b0);
    gap();
    check("after ferr left", left_o, 16'h5AA5);

    // reset in the middle of a frame
    for (int i = 0; i < 5; i++) begin
      ccyc(1'b0, 1'b0, 1'b0, 1'b0);
      ccyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    end
    rst_n = 1'b0;
    model_reset();
    w0 = wstb_cnt;
    repeat (3) tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    rst_n = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid rst left", left_o, 16'h0000);
    check("mid rst no strobe", wstb_cnt - w0, 0);
    send_frame(16'hC3C3, 8'h01, 16, 1'b0);
    gap();
    check("post rst right", right_o, 16'hC3C3);

    // randomized frames
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      rd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 8'h00;
        1: ra = 8'h01;
        default: ra = 8'($urandom);
      endcase
      co = 1'b0;
      if (r < 2) nb = $urandom_range(1, 15);
      else if (r < 4) begin nb = 16; co = 1'b1; end
      else if (r < 6) nb = $urandom_range(17, 20);
      else nb = 16;
      send_frame(rd, ra, nb, co);
      if (!co) gap();
    end

    // error counter saturation
    repeat (300) send_frame(16'($urandom), 8'($urandom), 9, 1'b0);
`ifdef JTDSP16_SIO_RX_ERR_EN
    check("err_cnt saturated", err_cnt_o, 8'hFF);
`else
    check("err_cnt tied", err_cnt_o, 8'h00);
`endif
    send_frame(16'h8001, 8'h01, 16, 1'b0);
    gap();
    check("final right", right_o, 16'h8001);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
